mdu_hilo: RTL

- Multiply/divide unit owning the HI/LO registers in the pipelined MIPS core; sits in EX beside the ALU.
- Consumes the decoder's `mulop`, `m`/`d` start strobes and mthi/mtlo writes.
- Runs mult/multu/div/divu over multiple cycles and raises `busy` so the hazard unit stalls mfhi/mflo/mthi/mtlo and further md instructions.

---
 rtl/mdu_pkg.sv | 36 +++
 rtl/mdu_divider.sv | 83 ++++++++
 rtl/mdu_hilo.sv | 125 ++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide unit.
//   - MULOP_* encodings (also used by the decoder)
//   - default latencies
//   - FSM state enums for the HI/LO controller and the iterative divider
//   - div32(): reference combinational divide returning {rem, quot}
package mdu_pkg;

  localparam logic [1:0] MULOP_MULT  = 2'd0;
  localparam logic [1:0] MULOP_MULTU = 2'd1;
  localparam logic [1:0] MULOP_DIV   = 2'd2;
  localparam logic [1:0] MULOP_DIVU  = 2'd3;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
  localparam int ITER_DIV_CYCLES = 34; // setup + 32 iterations + sign fix

  typedef enum logic {IDLE, RUN} state_t;
  typedef enum logic [1:0] {D_IDLE, D_SETUP, D_ITER, D_FIX} div_state_t;

  // Divide on magnitudes, then fix signs. This sidesteps the language's
  // signed-overflow behaviour for 0x80000000 / -1, which must give
  // quot=0x80000000, rem=0. A zero divisor yields 0/0; callers discard it.
  function automatic logic [63:0] div32(input logic [31:0] n,
                                        input logic [31:0] d,
                                        input logic        sgn);
    logic [31:0] na, da, q, r;
    na = (sgn && n[31]) ? -n : n;
    da = (sgn && d[31]) ? -d : d;
    q  = (da == 32'd0) ? 32'd0 : na / da;
    r  = (da == 32'd0) ? 32'd0 : na % da;
    q  = (sgn && (n[31] ^ d[31])) ? -q : q;
    r  = (sgn && n[31]) ? -r : r;
    return {r, q};
  endfunction

endpackage

// File: rtl/mdu_divider.sv
// mdu_divider: radix-2 restoring divider, used only when MDU_ITERATIVE_DIV_EN
// is defined.
//   clk, reset      clock, synchronous active-high reset
//   go              start (sampled only while idle); operands captured here
//   is_signed       1 = div, 0 = divu
//   dividend/divisor operands
//   done            high for the one sign-fix cycle; quot/rem valid then
//   quot, rem       results (rem carries the dividend's sign)
//   div_zero        divisor was zero; quot/rem are meaningless
// Timeline from go at edge N: setup at N+1, iterations at N+2..N+33,
// done during the cycle that ends at edge N+34.
module mdu_divider
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        go,
  input  logic        is_signed,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        done,
  output logic [31:0] quot,
  output logic [31:0] rem,
  output logic        div_zero
);

  div_state_t  st;
  logic [31:0] dvd;   // dividend magnitude, shifts left into quotient
  logic [31:0] dvs;
  logic [31:0] r;
  logic [4:0]  itc;
  logic        sgn, neg_q, neg_r;
  logic [33:0] r_sh, diff;

  // Restoring step: bring down the next dividend bit, try subtracting.
  assign r_sh = {1'b0, r, dvd[31]};
  assign diff = r_sh - {2'b00, dvs};

  always_ff @(posedge clk) begin
    if (reset) begin
      st       <= D_IDLE;
      dvd      <= '0;
      dvs      <= '0;
      r        <= '0;
      itc      <= '0;
      sgn      <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      case (st)
        D_IDLE: if (go) begin
          dvd <= dividend;
          dvs <= divisor;
          sgn <= is_signed;
          st  <= D_SETUP;
        end
        D_SETUP: begin
          neg_q    <= sgn & (dvd[31] ^ dvs[31]);
          neg_r    <= sgn & dvd[31];
          dvd      <= (sgn && dvd[31]) ? -dvd : dvd;
          dvs      <= (sgn && dvs[31]) ? -dvs : dvs;
          div_zero <= (dvs == 32'd0);
          r        <= '0;
          itc      <= '0;
          st       <= D_ITER;
        end
        D_ITER: begin
          r   <= diff[33] ? r_sh[31:0] : diff[31:0];
          dvd <= {dvd[30:0], ~diff[33]};
          itc <= itc + 5'd1;
          if (itc == 5'd31) st <= D_FIX;
        end
        default: st <= D_IDLE; // D_FIX: results presented combinationally
      endcase
    end
  end

  assign done = (st == D_FIX);
  assign quot = neg_q ? -dvd : dvd;
  assign rem  = neg_r ? -r : r;

endmodule

// File: rtl/mdu_hilo.sv
// mdu_hilo: multiply/divide unit owning HI/LO.
//   clk, reset   clock, synchronous active-high reset
//   start        begin operation (ignored while busy)
//   mulop        0 mult, 1 multu, 2 div, 3divu
//   a, b         rs / rt operands
//   hi_we, lo_we mthi / mtlo strobes (idle only; dropped if start)
//   wdata        mthi / mtlo data
//   busy         operation in progress (registered)
//   hi, lo       HI / LO registers
// Build option: MDU_ITERATIVE_DIV_EN selects the 34-cycle iterative divider;
// otherwise divide is combinational and DIV_CYCLES sets the latency.
module mdu_hilo
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
)(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  mulop,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

`ifdef MDU_ITERATIVE_DIV_EN
  localparam int DIV_LAT = ITER_DIV_CYCLES;
`else
  localparam int DIV_LAT = DIV_CYCLES;
`endif

  state_t      state, state_nxt;
  logic [7:0]  cnt;
  logic [31:0] a_q, b_q;
  logic [1:0]  op_q;
  logic        finish, dzero, wr_res;
  logic [63:0] ea, eb, prod, divres, res;

  // Sign- or zero-extend to 64 bits; the low 64 bits of the product are
  // then correct for both mult and multu.
  assign ea   = (op_q == MULOP_MULT) ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
  assign eb   = (op_q == MULOP_MULT) ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
  assign prod = ea * eb;

`ifdef MDU_ITERATIVE_DIV_EN
  logic        div_done, div_zero;
  logic [31:0] div_q, div_r;

  // The divider captures raw operands on the same edge the top latches them.
  mdu_divider u_div (
    .clk       (clk),
    .reset     (reset),
    .go        (start && (state == IDLE) && mulop[1]),
    .is_signed (~mulop[0]),
    .dividend  (a),
    .divisor   (b),
    .done      (div_done),
    .quot      (div_q),
    .rem       (div_r),
    .div_zero  (div_zero)
  );

  assign finish = op_q[1] ? div_done : (cnt == 8'd0);
  assign divres = {div_r, div_q};
  assign dzero  = div_zero;
`else
  assign finish = (cnt == 8'd0);
  assign divres = div32(a_q, b_q, ~op_q[0]);
  assign dzero  = (b_q == 32'd0);
`endif

  assign res    = op_q[1] ? divres : prod;
  assign wr_res = !(op_q[1] && dzero); // divide by zero leaves HI/LO alone
  assign busy   = (state == RUN);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)  state_nxt = RUN;
      RUN:     if (finish) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            a_q  <= a;
            b_q  <= b;
            op_q <= mulop;
            cnt  <= mulop[1] ? 8'(DIV_LAT - 1) : 8'(MULT_CYCLES - 1);
          end else begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
          end
        end
        default: begin
          if (finish) begin
            if (wr_res) {hi, lo} <= res;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
      endcase
    end
  end

endmodule
